// File: rtl/ddr3_fill_packer.sv
// Packs the 64-bit ADC stream into fills (header, data bursts, checksum) for the DDR3 write FIFO.
// Optional build macro: PACKER_TEST_PATTERN_EN replaces adc_dat with a 16-bit ramp counter.
`timescale 1ns/1ps
module ddr3_fill_packer #(
   parameter logic [22:0] ADDR_TOP   = 23'h7F_FFFF,
   parameter int          FILL_NUM_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           acq_enabled,
   input  logic           trig,
   input  logic [20:0]    fill_len,
   input  logic [63:0]    adc_dat,
   input  logic           adc_valid,
   input  logic           fifo_full,
   output logic           fifo_wr_en,
   output logic [127:0]   fifo_dat,
   output logic           busy,
   output logic           trig_missed,
   output logic           overflow_err,
   output logic [2:0]     fsm_state
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_ERR} state_t;
   state_t state, state_nx;

   logic [22:0]           next_addr, start_q;
   logic [FILL_NUM_W-1:0] fill_num;
   logic [20:0]           len_q, remaining;
   logic                  pair_have;
   logic [63:0]           pair_lo, sample;
   logic [125:0]          csum;

   logic                  trig_ok, word_done, hdr_wr, data_wr, csum_wr, ovf;
   logic [23:0]           a_fill, a_end, a_start, a_next;
   logic [22:0]           next_addr_nx, hdr_addr;
   logic [20:0]           hdr_len;
   logic [31:0]           fill_num32;
   logic [127:0]          hdr_word, data_word, csum_word;

`ifdef PACKER_TEST_PATTERN_EN
   logic [15:0] ramp;
   assign sample = {ramp + 16'd3, ramp + 16'd2, ramp + 16'd1, ramp};
   always_ff @(posedge clk) begin
      if (reset)          ramp <= '0;
      else if (trig_ok)   ramp <= '0;
      else if (adc_valid) ramp <= ramp + 16'd4;
   end
`else
   assign sample = adc_dat;
`endif

   assign trig_ok   = trig & acq_enabled & (state == S_IDLE);
   assign word_done = (state == S_DATA) & adc_valid & pair_have;
   assign busy      = (state != S_IDLE);
   assign fsm_state = state;

   // Circular allocator: a fill that would run past ADDR_TOP restarts at 0.
   assign a_fill       = {3'b000, fill_len} + 24'd2;
   assign a_end        = {1'b0, next_addr} + a_fill - 24'd1;
   assign a_start      = (a_end > {1'b0, ADDR_TOP}) ? 24'd0 : {1'b0, next_addr};
   assign a_next       = a_start + a_fill;
   assign next_addr_nx = (a_next > {1'b0, ADDR_TOP}) ? 23'd0 : a_next[22:0];

   // The header can leave straight from IDLE, so it uses the live length/address there.
   assign hdr_len    = (state == S_IDLE) ? fill_len : len_q;
   assign hdr_addr   = (state == S_IDLE) ? a_start[22:0] : start_q;
   assign fill_num32 = 32'(fill_num);
   assign hdr_word   = {2'b01, 41'd0, hdr_len, 6'd0, hdr_addr, 3'd0, fill_num32};
   assign data_word  = {sample, pair_lo};
   assign csum_word  = {2'b11, csum};

   always_comb begin
      state_nx = state;
      hdr_wr   = 1'b0;
      data_wr  = 1'b0;
      csum_wr  = 1'b0;
      ovf      = 1'b0;
      if (!acq_enabled) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (trig) begin
               if (!fifo_full) begin
                  hdr_wr   = 1'b1;
                  state_nx = (fill_len == '0) ? S_CSUM : S_DATA;
               end else begin
                  state_nx = S_HDR;
               end
            end
            S_HDR: if (!fifo_full) begin
               hdr_wr   = 1'b1;
               state_nx = (len_q == '0) ? S_CSUM : S_DATA;
            end
            S_DATA: if (word_done) begin
               if (fifo_full) begin
                  ovf      = 1'b1;
                  state_nx = S_ERR;
               end else begin
                  data_wr = 1'b1;
                  if (remaining == 21'd1) state_nx = S_CSUM;
               end
            end
            S_CSUM: if (!fifo_full) begin
               csum_wr  = 1'b1;
               state_nx = S_IDLE;
            end
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         fifo_wr_en   <= 1'b0;
         fifo_dat     <= '0;
         trig_missed  <= 1'b0;
         overflow_err <= 1'b0;
         next_addr    <= '0;
         start_q      <= '0;
         fill_num     <= '0;
         len_q        <= '0;
         remaining    <= '0;
         pair_have    <= 1'b0;
         pair_lo      <= '0;
         csum         <= '0;
      end else begin
         state       <= state_nx;
         fifo_wr_en  <= hdr_wr | data_wr | csum_wr;
         trig_missed <= trig & ~trig_ok;
         if (hdr_wr)       fifo_dat <= hdr_word;
         else if (data_wr) fifo_dat <= data_word;
         else if (csum_wr) fifo_dat <= csum_word;
         if (ovf) overflow_err <= 1'b1;
         if (trig_ok) begin
            len_q     <= fill_len;
            start_q   <= a_start[22:0];
            next_addr <= next_addr_nx;
         end
         if (hdr_wr) begin
            fill_num  <= fill_num + 1'b1;
            remaining <= hdr_len;
         end
         // Abort drops any half-built word and the running checksum.
         if (!acq_enabled) begin
            pair_have <= 1'b0;
            pair_lo   <= '0;
            csum      <= '0;
         end else begin
            if (state == S_DATA && adc_valid) begin
               pair_have <= ~pair_have;
               if (!pair_have) pair_lo <= sample;
            end
            if (data_wr) begin
               csum      <= csum ^ data_word[125:0];
               remaining <= remaining - 21'd1;
            end
            if (csum_wr) csum <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ddr3_fill_packer.sv
// Scoreboard bench for ddr3_fill_packer: expected FIFO words are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_ddr3_fill_packer;
   localparam logic [22:0] TOP = 23'd9;

   logic          clk = 1'b0;
   logic          reset, acq_enabled, trig, adc_valid, fifo_full;
   logic [20:0]   fill_len;
   logic [63:0]   adc_dat;
   logic          fifo_wr_en, busy, trig_missed, overflow_err;
   logic [127:0]  fifo_dat;
   logic [2:0]    fsm_state;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [127:0]  exp_q[$];
   int            m_next_addr = 0;
   int            m_fill_num = 0;
   logic [125:0]  m_csum = '0;
   logic [15:0]   m_ramp = '0;

   ddr3_fill_packer #(.ADDR_TOP(TOP), .FILL_NUM_W(32)) dut (
      .clk(clk), .reset(reset), .acq_enabled(acq_enabled), .trig(trig),
      .fill_len(fill_len), .adc_dat(adc_dat), .adc_valid(adc_valid),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_dat(fifo_dat),
      .busy(busy), .trig_missed(trig_missed), .overflow_err(overflow_err),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Every FIFO write is matched against the head of the expected queue.
   initial forever begin
      @(negedge clk);
      if (reset === 1'b0 && fifo_wr_en === 1'b1) begin
         if (exp_q.size() == 0) check("write_with_empty_queue", {127'd0, fifo_wr_en}, 128'd0);
         else check("fifo_word", fifo_dat, exp_q.pop_front());
      end
   end

   task automatic get_sample(output logic [63:0] s);
`ifdef PACKER_TEST_PATTERN_EN
      s = {m_ramp + 16'd3, m_ramp + 16'd2, m_ramp + 16'd1, m_ramp};
      m_ramp = m_ramp + 16'd4;
`else
      s = {$urandom, $urandom};
`endif
   endtask

   // Drives an accepted trigger (with a junk adc_valid that must be discarded).
   task automatic start_fill(input int len);
      int f, st;
      logic [127:0] h;
      f  = len + 2;
      st = (m_next_addr + f - 1 > int'(TOP)) ? 0 : m_next_addr;
      m_next_addr = st + f;
      if (m_next_addr > int'(TOP)) m_next_addr = 0;
      h = '0;
      h[127:126] = 2'b01;
      h[84:64]   = len[20:0];
      h[57:35]   = st[22:0];
      h[31:0]    = m_fill_num;
      m_fill_num++;
      m_csum = '0;
      exp_q.push_back(h);
      if (len == 0) exp_q.push_back({2'b11, 126'd0});
      trig = 1'b1; fill_len = len[20:0]; adc_valid = 1'b1; adc_dat = {$urandom, $urandom};
      @(negedge clk);
      trig = 1'b0; adc_valid = 1'b0; m_ramp = '0;
      if (fifo_full == 1'b0) check("hdr_latency", {127'd0, fifo_wr_en}, 128'd1);
   endtask

   task automatic send_word(input bit last, input bit drop);
      logic [63:0] lo, hi;
      logic [127:0] w;
      get_sample(lo);
      adc_valid = 1'b1; adc_dat = lo;
      @(negedge clk);
      adc_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      get_sample(hi);
      w = {hi, lo};
      fifo_full = drop; adc_valid = 1'b1; adc_dat = hi;
      if (!drop) begin
         exp_q.push_back(w);
         m_csum = m_csum ^ w[125:0];
         if (last) exp_q.push_back({2'b11, m_csum});
      end
      @(negedge clk);
      adc_valid = 1'b0; fifo_full = 1'b0;
      if (!drop) check("data_latency", {127'd0, fifo_wr_en}, 128'd1);
   endtask

   task automatic end_fill();
      @(negedge clk);
      check("csum_latency", {127'd0, fifo_wr_en}, 128'd1);
      @(negedge clk);
      check("busy_after_fill", {127'd0, busy}, 128'd0);
   endtask

   task automatic full_fill(input int len);
      start_fill(len);
      for (int i = 0; i < len; i++) send_word(i == len - 1, 1'b0);
      if (len == 0) begin
         @(negedge clk);
         check("csum_after_hdr", {127'd0, fifo_wr_en}, 128'd1);
         @(negedge clk);
         check("busy_after_fill", {127'd0, busy}, 128'd0);
      end else begin
         end_fill();
      end
   endtask

   initial begin
      reset = 1'b1; acq_enabled = 1'b1; trig = 1'b0; adc_valid = 1'b0;
      fifo_full = 1'b0; fill_len = '0; adc_dat = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_wr_en", {127'd0, fifo_wr_en}, 128'd0);
      check("rst_dat", fifo_dat, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_trig_missed", {127'd0, trig_missed}, 128'd0);
      check("rst_overflow", {127'd0, overflow_err}, 128'd0);

      // Basic fill at address 0; leaves next_addr at 6.
      full_fill(4);

      // Header held off by a full FIFO; this fill wraps to address 0.
      fifo_full = 1'b1;
      start_fill(4);
      check("hdr_wait_no_write", {127'd0, fifo_wr_en}, 128'd0);
      check("hdr_wait_busy", {127'd0, busy}, 128'd1);
      fifo_full = 1'b0;
      @(negedge clk);
      check("hdr_after_wait", {127'd0, fifo_wr_en}, 128'd1);
      for (int i = 0; i < 4; i++) send_word(i == 3, 1'b0);
      end_fill();

      // Exact fit at 6..9 then next_addr returns to 0; empty fill lands at 0.
      full_fill(2);
      full_fill(0);

      // Trigger while busy, trigger while disabled, abort mid-data.
      start_fill(3);
      repeat (2) @(negedge clk);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      check("trig_missed_busy", {127'd0, trig_missed}, 128'd1);
      send_word(1'b0, 1'b0);
      acq_enabled = 1'b0;
      @(negedge clk);
      check("abort_idle", {127'd0, busy}, 128'd0);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      check("trig_missed_disabled", {127'd0, trig_missed}, 128'd1);
      acq_enabled = 1'b1;
      repeat (3) @(negedge clk);

      // Word completion against a full FIFO -> overflow, error hold, abort keeps the flag.
      start_fill(3);
      send_word(1'b0, 1'b0);
      send_word(1'b0, 1'b1);
      check("overflow_set", {127'd0, overflow_err}, 128'd1);
      check("err_busy", {127'd0, busy}, 128'd1);
      adc_valid = 1'b1;
      repeat (4) @(negedge clk);
      adc_valid = 1'b0;
      check("err_still_busy", {127'd0, busy}, 128'd1);
      acq_enabled = 1'b0;
      @(negedge clk);
      acq_enabled = 1'b1;
      check("err_cleared_idle", {127'd0, busy}, 128'd0);
      check("overflow_sticky", {127'd0, overflow_err}, 128'd1);

      // Recovery fill after the error.
      full_fill(2);

      repeat (5) @(negedge clk);
      check("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
